// File: rtl/hilo_pkg.sv
// Shared op codes, FSM state encodings and default width for the HI/LO mul/div unit.
package hilo_pkg;

   localparam int unsigned WIDTH_DEF = 32;

   localparam logic [2:0] OP_MTHI  = 3'd0;
   localparam logic [2:0] OP_MTLO  = 3'd1;
   localparam logic [2:0] OP_MULT  = 3'd2;
   localparam logic [2:0] OP_MULTU = 3'd3;
   localparam logic [2:0] OP_DIV   = 3'd4;
   localparam logic [2:0] OP_DIVU  = 3'd5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   function automatic logic op_is_muldiv(input logic [2:0] code);
      return (code == OP_MULT) || (code == OP_MULTU) || (code == OP_DIV) || (code == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [2:0] code);
      return (code == OP_MULT) || (code == OP_DIV);
   endfunction

   function automatic logic op_is_div(input logic [2:0] code);
      return (code == OP_DIV) || (code == OP_DIVU);
   endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX stage (master) and the HI/LO unit (slave).
interface hilo_muldiv_unit_if
   import hilo_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
);

   logic             op_valid;
   logic [2:0]       op_code;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             flush;
   logic             op_ready;
   logic             busy;
   logic             done;
   logic             div0;
   logic [WIDTH-1:0] rhi;
   logic [WIDTH-1:0] rlo;

   modport master (
      output op_valid, op_code, op_a, op_b, flush,
      input  op_ready, busy, done, div0, rhi, rlo
   );

   modport slave (
      input  op_valid, op_code, op_a, op_b, flush,
      output op_ready, busy, done, div0, rhi, rlo
   );

endinterface

// File: rtl/muldiv_iter_core.sv
// Magnitude datapath: shift-add multiply or restoring divide, one iteration per step.
// After WIDTH steps acc holds {hi,lo} = product, or {remainder, quotient}.
module muldiv_iter_core
   import hilo_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] acc
);

   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   b_q;
   logic               div_q;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     rem_ext;
   logic [WIDTH:0]     diff;

   // Multiplier sits in the low half and is consumed LSB-first; dividend shifts out of the low half
   // into the partial remainder while quotient bits fill in from the bottom.
   always_comb begin
      add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
      rem_ext = acc_q[2*WIDTH-1:WIDTH-1];
      diff    = rem_ext - {1'b0, b_q};
      acc_nxt = acc_q;
      if (div_q) begin
         if (!diff[WIDTH])
            acc_nxt = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else
            acc_nxt = {acc_q[2*WIDTH-2:0], 1'b0};
      end else begin
         if (acc_q[0])
            acc_nxt = {add_sum, acc_q[WIDTH-1:1]};
         else
            acc_nxt = {1'b0, acc_q[2*WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
      end else if (load) begin
         acc_q <= {{WIDTH{1'b0}}, a};
         b_q   <= b;
         div_q <= is_div;
      end else if (step) begin
         acc_q <= acc_nxt;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register unit with iterative mul/div engine (IDLE -> RUN -> FIX -> IDLE).
// Define HILO_FWD_EN to bypass the value being written onto rhi/rlo in the same cycle.
module hilo_muldiv_unit
   import hilo_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   hilo_muldiv_unit_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic [1:0]         state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               div_q;
   logic               qneg_q;
   logic               rneg_q;
   logic               zero_q;
   logic               done_q;
   logic               div0_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               idle;
   logic               accept;
   logic               start_md;
   logic               sgn;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic               hi_we;
   logic               lo_we;
   logic [WIDTH-1:0]   hi_wd;
   logic [WIDTH-1:0]   lo_wd;

   assign idle     = (state_q == ST_IDLE);
   assign accept   = bus.op_valid && idle;
   assign start_md = accept && op_is_muldiv(bus.op_code);
   assign sgn      = op_is_signed(bus.op_code);
   assign a_neg    = sgn && bus.op_a[WIDTH-1];
   assign b_neg    = sgn && bus.op_b[WIDTH-1];
   assign a_mag    = a_neg ? -bus.op_a : bus.op_a;
   assign b_mag    = b_neg ? -bus.op_b : bus.op_b;

   muldiv_iter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (start_md),
      .step   (state_q == ST_RUN),
      .is_div (op_is_div(bus.op_code)),
      .a      (a_mag),
      .b      (b_mag),
      .acc    (acc)
   );

   // Signed results are rebuilt from magnitudes; MIN/-1 wraps to MIN naturally.
   always_comb begin
      prod = qneg_q ? -acc : acc;
      quo  = qneg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem  = rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      hi_we = 1'b0;
      lo_we = 1'b0;
      hi_wd = hi_q;
      lo_wd = lo_q;
      if (idle) begin
         if (accept && bus.op_code == OP_MTHI) begin
            hi_we = 1'b1;
            hi_wd = bus.op_a;
         end
         if (accept && bus.op_code == OP_MTLO) begin
            lo_we = 1'b1;
            lo_wd = bus.op_a;
         end
      end else if (state_q == ST_FIX && !bus.flush && !(div_q && zero_q)) begin
         hi_we = 1'b1;
         lo_we = 1'b1;
         hi_wd = div_q ? rem : prod[2*WIDTH-1:WIDTH];
         lo_wd = div_q ? quo : prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         zero_q  <= 1'b0;
         done_q  <= 1'b0;
         div0_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         done_q <= 1'b0;
         div0_q <= 1'b0;
         if (hi_we) hi_q <= hi_wd;
         if (lo_we) lo_q <= lo_wd;
         case (state_q)
            ST_IDLE: begin
               if (start_md) begin
                  state_q <= ST_RUN;
                  cnt_q   <= CNT_W'(WIDTH);
                  div_q   <= op_is_div(bus.op_code);
                  qneg_q  <= a_neg ^ b_neg;
                  rneg_q  <= a_neg;
                  zero_q  <= (bus.op_b == '0);
               end
            end
            ST_RUN: begin
               if (bus.flush) begin
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == CNT_W'(1)) state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               state_q <= ST_IDLE;
               if (!bus.flush) begin
                  done_q <= 1'b1;
                  div0_q <= div_q && zero_q;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.op_ready = idle;
   assign bus.busy     = !idle;
   assign bus.done     = done_q;
   assign bus.div0     = div0_q;

`ifdef HILO_FWD_EN
   assign bus.rhi = hi_we ? hi_wd : hi_q;
   assign bus.rlo = lo_we ? lo_wd : lo_q;
`else
   assign bus.rhi = hi_q;
   assign bus.rlo = lo_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed + randomized bench for hilo_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv_unit;
   import hilo_pkg::*;

   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;

   hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

   hilo_muldiv_unit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: architectural result of one mul/div, from plain integer arithmetic.
   task automatic model_md(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] hi, output logic [W-1:0] lo, output logic z);
      longint          sp, sa, sb, sq, sr;
      longint unsigned up;
      hi = exp_hi;
      lo = exp_lo;
      z  = 1'b0;
      case (code)
         OP_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            {hi, lo} = sp;
         end
         OP_MULTU: begin
            up = {32'b0, a} * {32'b0, b};
            {hi, lo} = up;
         end
         OP_DIV: begin
            if (b == 0) z = 1'b1;
            else begin
               sa = longint'($signed(a));
               sb = longint'($signed(b));
               sq = sa / sb;
               sr = sa % sb;
               lo = sq[W-1:0];
               hi = sr[W-1:0];
            end
         end
         default: begin
            if (b == 0) z = 1'b1;
            else begin
               lo = a / b;
               hi = a % b;
            end
         end
      endcase
   endtask

   task automatic issue_mt(input logic [2:0] code, input logic [W-1:0] data);
      bus.op_valid = 1'b1;
      bus.op_code  = code;
      bus.op_a     = data;
      bus.op_b     = $urandom;
      tick();
      bus.op_valid = 1'b0;
      if (code == OP_MTHI) exp_hi = data;
      if (code == OP_MTLO) exp_lo = data;
      chk("mt_hi", bus.rhi, exp_hi);
      chk("mt_lo", bus.rlo, exp_lo);
      chk("mt_busy", bus.busy, 1'b0);
   endtask

   // Issues a mul/div in the current cycle and follows it to done; optional MTLO poke while busy.
   task automatic run_md(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke);
      logic [W-1:0] nhi, nlo;
      logic         z;
      int           k;
      bit           seen;
      model_md(code, a, b, nhi, nlo, z);
      chk("md_ready", bus.op_ready, 1'b1);
      bus.op_valid = 1'b1;
      bus.op_code  = code;
      bus.op_a     = a;
      bus.op_b     = b;
      tick();
      bus.op_valid = 1'b0;
      chk("md_busy0", bus.busy, 1'b1);
      chk("md_nodone0", bus.done, 1'b0);
      k    = 0;
      seen = 1'b0;
      while (!seen && k < int'(W) + 8) begin
         if (poke && k == 5) begin
            bus.op_valid = 1'b1;
            bus.op_code  = OP_MTLO;
            bus.op_a     = 32'hDEAD_BEEF;
         end
         tick();
         k++;
         bus.op_valid = 1'b0;
         if (poke && k == 6) chk("busy_mtlo_ignored", bus.rlo, exp_lo);
         if (k == int'(W)) begin
            chk("fix_busy", bus.busy, 1'b1);
`ifdef HILO_FWD_EN
            chk("fix_fwd_lo", bus.rlo, z ? exp_lo : nlo);
`else
            chk("fix_lo_old", bus.rlo, exp_lo);
`endif
         end
         if (bus.done === 1'b1) seen = 1'b1;
      end
      exp_hi = nhi;
      exp_lo = nlo;
      chk("md_latency", 64'(k), 64'(W + 1));
      chk("md_div0", bus.div0, z);
      chk("md_hi", bus.rhi, exp_hi);
      chk("md_lo", bus.rlo, exp_lo);
      chk("md_ready_done", bus.op_ready, 1'b1);
   endtask

   initial begin
      int  cnt_done;
      logic [2:0] rc;
      logic [W-1:0] ra, rb;
      bus.op_valid = 1'b0;
      bus.op_code  = OP_MTHI;
      bus.op_a     = '0;
      bus.op_b     = '0;
      bus.flush    = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_hi", bus.rhi, '0);
      chk("rst_lo", bus.rlo, '0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_div0", bus.div0, 1'b0);
      chk("rst_ready", bus.op_ready, 1'b1);

      issue_mt(OP_MTHI, 32'h1234_5678);

      run_md(OP_MULT,  32'hFFFF_FFFF, 32'd2, 1'b0);
      chk("mult_hi_const", bus.rhi, 32'hFFFF_FFFF);
      chk("mult_lo_const", bus.rlo, 32'hFFFF_FFFE);
      run_md(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      chk("multu_hi_const", bus.rhi, 32'h0000_0001);
      run_md(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
      chk("div_lo_const", bus.rlo, 32'hFFFF_FFFD);
      run_md(OP_DIVU,  32'd7, 32'd2, 1'b0);
      chk("divu_lo_const", bus.rlo, 32'd3);
      run_md(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("divmin_lo_const", bus.rlo, 32'h8000_0000);
      chk("divmin_hi_const", bus.rhi, 32'h0);

      tick();
      issue_mt(OP_MTHI, 32'hA);
      issue_mt(OP_MTLO, 32'hB);
      run_md(OP_DIVU, 32'd5, 32'd0, 1'b0);
      tick();
      chk("div0_pulse", bus.div0, 1'b0);
      chk("done_pulse", bus.done, 1'b0);

      run_md(OP_MULTU, 32'h0001_0003, 32'h0002_0005, 1'b1);

      // Flush ten cycles into a MULT, then an MTLO right after.
      bus.op_valid = 1'b1;
      bus.op_code  = OP_MULT;
      bus.op_a     = 32'h7;
      bus.op_b     = 32'h9;
      tick();
      bus.op_valid = 1'b0;
      repeat (9) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("flush_busy", bus.busy, 1'b0);
      chk("flush_hi", bus.rhi, exp_hi);
      chk("flush_lo", bus.rlo, exp_lo);
      issue_mt(OP_MTLO, 32'h5555_AAAA);
      cnt_done = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done === 1'b1) cnt_done++;
      end
      chk("flush_nodone", 64'(cnt_done), 64'd0);
      chk("flush_hold_hi", bus.rhi, exp_hi);

      // Flush with op_valid in IDLE still accepts; unknown code is a no-op.
      bus.flush = 1'b1;
      issue_mt(OP_MTHI, 32'hCAFE_0001);
      bus.flush = 1'b0;
      issue_mt(3'd6, 32'h0BAD_0BAD);

      // Reset in the middle of a DIV discards it and clears HI/LO.
      bus.op_valid = 1'b1;
      bus.op_code  = OP_DIV;
      bus.op_a     = 32'd100;
      bus.op_b     = 32'd7;
      tick();
      bus.op_valid = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      chk("midrst_busy", bus.busy, 1'b0);
      chk("midrst_hi", bus.rhi, '0);
      chk("midrst_lo", bus.rlo, '0);

      for (int n = 0; n < 16; n++) begin
         rc = 3'($urandom_range(2, 5));
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = '0;
            1:       rb = 32'd1;
            2:       rb = 32'hFFFF_FFFF;
            3:       rb = 32'($urandom_range(2, 20));
            default: rb = $urandom;
         endcase
         run_md(rc, ra, rb, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
